de0_nano_sopc_cpu_div_cell: RTL and testbench



---
 rtl/de0_nano_sopc_cpu_div_cell.sv | 110 +++++++++++
 tb/tb_de0_nano_sopc_cpu_div_cell.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/de0_nano_sopc_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II A-stage.
// One quotient bit per clock, signed (truncating) or unsigned.
module de0_nano_sopc_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    input  logic             A_div_signed,
    input  logic             A_div_start,
    output logic             A_div_busy,
    output logic             A_div_done,
    output logic [WIDTH-1:0] A_div_quotient,
    output logic [WIDTH-1:0] A_div_remainder,
    output logic             A_div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;
    logic             zero;

    logic             accept;
    logic             neg1;
    logic             neg2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        accept  = A_div_start && (state == S_IDLE || state == S_DONE);
        neg1    = A_div_signed && A_div_src1[WIDTH-1];
        neg2    = A_div_signed && A_div_src2[WIDTH-1];
        mag1    = neg1 ? -A_div_src1 : A_div_src1;
        mag2    = neg2 ? -A_div_src2 : A_div_src2;
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr};
        // A zero divisor leaves rem = |src1|, so the sign fix restores src1.
        q_fix   = zero ? '1 : (q_neg ? -dvd : dvd);
        r_fix   = r_neg ? -rem : rem;
    end

    assign A_div_busy = (state == S_RUN) || (state == S_FIX);
    assign A_div_done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            rem             <= '0;
            dvd             <= '0;
            dvsr            <= '0;
            cnt             <= '0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            zero            <= 1'b0;
            A_div_quotient  <= '0;
            A_div_remainder <= '0;
            A_div_by_zero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        dvd   <= mag1;
                        dvsr  <= mag2;
                        rem   <= '0;
                        cnt   <= '0;
                        r_neg <= neg1;
                        q_neg <= neg1 ^ neg2;
                        zero  <= (A_div_src2 == '0);
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    rem <= trial[WIDTH] ? shifted[WIDTH-1:0]
                                        : trial[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= S_FIX;
                end
                S_FIX: begin
                    A_div_quotient  <= q_fix;
                    A_div_remainder <= r_fix;
                    A_div_by_zero   <= zero;
                    state           <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_de0_nano_sopc_cpu_div_cell.sv
// Scoreboard bench for the iterative divider: random and directed
// operands checked against plain-arithmetic division.
module tb_de0_nano_sopc_cpu_div_cell;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           e0;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         sgn;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rmd;
    logic         dbz;

    exp_t sb[$];
    int   cyc = 0;
    int   bcnt = 0;
    int   nchk = 0;
    int   npass = 0;
    int   last_done = 0;

    de0_nano_sopc_cpu_div_cell #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .A_div_src1      (src1),
        .A_div_src2      (src2),
        .A_div_signed    (sgn),
        .A_div_start     (start),
        .A_div_busy      (busy),
        .A_div_done      (done),
        .A_div_quotient  (quo),
        .A_div_remainder (rmd),
        .A_div_by_zero   (dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                   logic s);
        exp_t   e;
        longint sa;
        longint sb_;
        longint lq;
        longint lr;
        e.e0 = 0;
        e.z  = (b == 0);
        if (b == 0) begin
            e.q = '1;
            e.r = a;
        end else if (s) begin
            sa   = longint'($signed(a));
            sb_  = longint'($signed(b));
            lq   = sa / sb_;
            lr   = sa % sb_;
            e.q  = lq[W-1:0];
            e.r  = lr[W-1:0];
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic check(input string name, input bit ok,
                         input string got, input string want);
        nchk++;
        if (ok) npass++;
        else $display("FAIL %s: got %s expected %s", name, got, want);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1'b0, "done", "no done");
                end else begin
                    e = sb.pop_front();
                    check("result", quo === e.q && rmd === e.r && dbz === e.z,
                          $sformatf("q=%h r=%h z=%b", quo, rmd, dbz),
                          $sformatf("q=%h r=%h z=%b", e.q, e.r, e.z));
                    check("timing",
                          cyc == e.e0 + W + 1 && bcnt == W + 1 && !busy,
                          $sformatf("lat=%0d busy_cycles=%0d busy=%b",
                                    cyc - e.e0, bcnt, busy),
                          $sformatf("lat=%0d busy_cycles=%0d busy=0",
                                    W + 1, W + 1));
                end
                last_done = cyc;
                bcnt = 0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
        exp_t e;
        e    = model(a, b, s);
        e.e0 = cyc + 1;
        sb.push_back(e);
        src1  = a;
        src2  = b;
        sgn   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        sgn   = $urandom_range(0, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) check("done_timeout", 1'b0, "no done", "done");
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s);
        issue(a, b, s);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        int  d1;
        bit  seen;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset_n = 1'b0;
        start   = 1'b0;
        src1    = '0;
        src2    = '0;
        sgn     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, done, dbz} == 3'b000 && quo == '0 && rmd == '0,
              $sformatf("b=%b d=%b q=%h r=%h z=%b", busy, done, quo, rmd, dbz),
              "all zero");
        reset_n = 1'b1;
        @(negedge clk);

        op(32'd100, 32'd7, 1'b0);
        op(32'hFFFF_FFF9, 32'd2, 1'b1);
        op(32'd7, 32'hFFFF_FFFE, 1'b1);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        op(32'hFFFF_FFFF, 32'd1, 1'b0);
        op(32'd1234, 32'd0, 1'b1);
        op(32'd1234, 32'd0, 1'b0);
        op(32'hFFFF_FB2E, 32'd0, 1'b1);
        op(32'h8000_0000, 32'd0, 1'b1);

        // second start while running must be dropped
        issue(32'd1000, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        src1  = 32'd55;
        src2  = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // start in the done cycle
        issue(32'd999, 32'd10, 1'b0);
        wait_done();
        d1 = cyc;
        issue(32'hFFFF_FF00, 32'd16, 1'b1);
        wait_done();
        check("b2b_period", cyc - d1 == W + 2,
              $sformatf("%0d", cyc - d1), $sformatf("%0d", W + 2));
        @(negedge clk);

        // reset mid-run
        issue(32'd12345, 32'd17, 1'b0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("midrun_reset",
              {busy, done, dbz} == 3'b000 && quo == '0 && rmd == '0,
              $sformatf("b=%b d=%b q=%h r=%h z=%b", busy, done, quo, rmd, dbz),
              "all zero");
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("no_done_after_reset", !seen, "activity", "idle");
        op(32'd12345, 32'd17, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 20));
                3:       b = -W'($urandom_range(1, 20));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 49) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            issue(a, b, 1'($urandom_range(0, 1)));
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size() == 0,
              $sformatf("%0d left", sb.size()), "0 left");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
